// File: rtl/core_jtag_debug_if.sv
`default_nettype none
// ============================================================================
// Module      : core_jtag_debug_if
// Description : Host and per-target JTAG signal bundle for core_jtag_debug.
//               Host side: TMS, TDI in; TDO out.
//               Target side (bit n serves target n): TGT_TCK, TGT_TMS,
//               TGT_TDI, TGT_TRSTB out; TGT_TDO in.
//               master = host/targets environment, slave = debug block.
// Revision    : 1.0 - initial release
// ============================================================================
interface core_jtag_debug_if;
    logic        TMS;
    logic        TDI;
    logic        TDO;
    logic [15:0] TGT_TCK;
    logic [15:0] TGT_TMS;
    logic [15:0] TGT_TDI;
    logic [15:0] TGT_TRSTB;
    logic [15:0] TGT_TDO;

    modport master (
        output TMS, TDI, TGT_TDO,
        input  TDO, TGT_TCK, TGT_TMS, TGT_TDI, TGT_TRSTB
    );

    modport slave (
        input  TMS, TDI, TGT_TDO,
        output TDO, TGT_TCK, TGT_TMS, TGT_TDI, TGT_TRSTB
    );
endinterface
`default_nettype wire

// File: rtl/core_jtag_debug.sv
`default_nettype none
// ============================================================================
// Module      : core_jtag_debug
// Description : IEEE 1149.1 TAP that routes a host JTAG port to one of up to
//               16 debug targets selected by an 8-bit IR code.
//   Ports     : TCK  - sole clock (rising edge)
//               TRST - synchronous active-high reset
//               bus  - core_jtag_debug_if.slave (host TMS/TDI/TDO and the
//                      per-target TCK/TMS/TDI/TRSTB/TDO vectors)
//   Option    : CORE_JTAG_DEBUG_IDCODE_EN - adds a 32-bit IDCODE register
//               selected by IR 8'h01 (IR reset value becomes 8'h01).
// Revision    : 1.0 - initial release
// ============================================================================
module core_jtag_debug #(
`ifdef CORE_JTAG_DEBUG_IDCODE_EN
    parameter logic [31:0] IDCODE = 32'h1000_0CFD,
`endif
    parameter int          NUM_DEBUG_TGTS = 16,
    parameter int          FAMILY = 19,
    parameter logic [7:0]  IR_CODE_TGT_0  = 8'h55, IR_CODE_TGT_1  = 8'h56,
    parameter logic [7:0]  IR_CODE_TGT_2  = 8'h57, IR_CODE_TGT_3  = 8'h58,
    parameter logic [7:0]  IR_CODE_TGT_4  = 8'h59, IR_CODE_TGT_5  = 8'h5A,
    parameter logic [7:0]  IR_CODE_TGT_6  = 8'h5B, IR_CODE_TGT_7  = 8'h5C,
    parameter logic [7:0]  IR_CODE_TGT_8  = 8'h5D, IR_CODE_TGT_9  = 8'h5E,
    parameter logic [7:0]  IR_CODE_TGT_10 = 8'h5F, IR_CODE_TGT_11 = 8'h60,
    parameter logic [7:0]  IR_CODE_TGT_12 = 8'h61, IR_CODE_TGT_13 = 8'h62,
    parameter logic [7:0]  IR_CODE_TGT_14 = 8'h63, IR_CODE_TGT_15 = 8'h64,
    parameter bit TGT_ACTIVE_HIGH_RESET_0  = 1'b0, TGT_ACTIVE_HIGH_RESET_1  = 1'b0,
    parameter bit TGT_ACTIVE_HIGH_RESET_2  = 1'b0, TGT_ACTIVE_HIGH_RESET_3  = 1'b0,
    parameter bit TGT_ACTIVE_HIGH_RESET_4  = 1'b0, TGT_ACTIVE_HIGH_RESET_5  = 1'b0,
    parameter bit TGT_ACTIVE_HIGH_RESET_6  = 1'b0, TGT_ACTIVE_HIGH_RESET_7  = 1'b0,
    parameter bit TGT_ACTIVE_HIGH_RESET_8  = 1'b0, TGT_ACTIVE_HIGH_RESET_9  = 1'b0,
    parameter bit TGT_ACTIVE_HIGH_RESET_10 = 1'b0, TGT_ACTIVE_HIGH_RESET_11 = 1'b0,
    parameter bit TGT_ACTIVE_HIGH_RESET_12 = 1'b0, TGT_ACTIVE_HIGH_RESET_13 = 1'b0,
    parameter bit TGT_ACTIVE_HIGH_RESET_14 = 1'b0, TGT_ACTIVE_HIGH_RESET_15 = 1'b0
) (
    input  wire                TCK,
    input  wire                TRST,
    core_jtag_debug_if.slave   bus
);

    localparam logic [7:0] c_ir_code [16] = '{
        IR_CODE_TGT_0,  IR_CODE_TGT_1,  IR_CODE_TGT_2,  IR_CODE_TGT_3,
        IR_CODE_TGT_4,  IR_CODE_TGT_5,  IR_CODE_TGT_6,  IR_CODE_TGT_7,
        IR_CODE_TGT_8,  IR_CODE_TGT_9,  IR_CODE_TGT_10, IR_CODE_TGT_11,
        IR_CODE_TGT_12, IR_CODE_TGT_13, IR_CODE_TGT_14, IR_CODE_TGT_15};

    localparam logic [15:0] c_active_high = {
        TGT_ACTIVE_HIGH_RESET_15, TGT_ACTIVE_HIGH_RESET_14,
        TGT_ACTIVE_HIGH_RESET_13, TGT_ACTIVE_HIGH_RESET_12,
        TGT_ACTIVE_HIGH_RESET_11, TGT_ACTIVE_HIGH_RESET_10,
        TGT_ACTIVE_HIGH_RESET_9,  TGT_ACTIVE_HIGH_RESET_8,
        TGT_ACTIVE_HIGH_RESET_7,  TGT_ACTIVE_HIGH_RESET_6,
        TGT_ACTIVE_HIGH_RESET_5,  TGT_ACTIVE_HIGH_RESET_4,
        TGT_ACTIVE_HIGH_RESET_3,  TGT_ACTIVE_HIGH_RESET_2,
        TGT_ACTIVE_HIGH_RESET_1,  TGT_ACTIVE_HIGH_RESET_0};

`ifdef CORE_JTAG_DEBUG_IDCODE_EN
    localparam logic [7:0] c_ir_reset = 8'h01;
`else
    localparam logic [7:0] c_ir_reset = 8'hFF;
`endif

    typedef enum logic [3:0] {
        ST_TLR      = 4'd0,  ST_RTI      = 4'd1,
        ST_SEL_DR   = 4'd2,  ST_CAP_DR   = 4'd3,
        ST_SHIFT_DR = 4'd4,  ST_EXIT1_DR = 4'd5,
        ST_PAUSE_DR = 4'd6,  ST_EXIT2_DR = 4'd7,
        ST_UPD_DR   = 4'd8,  ST_SEL_IR   = 4'd9,
        ST_CAP_IR   = 4'd10, ST_SHIFT_IR = 4'd11,
        ST_EXIT1_IR = 4'd12, ST_PAUSE_IR = 4'd13,
        ST_EXIT2_IR = 4'd14, ST_UPD_IR   = 4'd15
    } tap_state_t;

    tap_state_t  r_state;
    tap_state_t  w_state_next;
    logic [7:0]  r_ir;
    logic [7:0]  r_ir_sr;
    logic        r_bypass;
    // Cleared by any reset so that "no target" holds even if a target code
    // happens to equal the IR reset value.
    logic        r_sel_en;
    logic        w_sel_valid;
    logic [3:0]  w_sel_idx;
    logic        w_tdo;
    logic        w_rst_active;
    logic [15:0] w_tgt_tck, w_tgt_tms, w_tgt_tdi, w_tgt_trstb;
`ifdef CORE_JTAG_DEBUG_IDCODE_EN
    logic [31:0] r_idcode_sr;
    logic        w_idcode_sel;
    assign w_idcode_sel = (r_ir == 8'h01);
`endif

    // ---------------- TAP state register ----------------
    always_ff @(posedge TCK) begin
        if (TRST) r_state <= ST_TLR;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_TLR:      w_state_next = bus.TMS ? ST_TLR      : ST_RTI;
            ST_RTI:      w_state_next = bus.TMS ? ST_SEL_DR   : ST_RTI;
            ST_SEL_DR:   w_state_next = bus.TMS ? ST_SEL_IR   : ST_CAP_DR;
            ST_CAP_DR:   w_state_next = bus.TMS ? ST_EXIT1_DR : ST_SHIFT_DR;
            ST_SHIFT_DR: w_state_next = bus.TMS ? ST_EXIT1_DR : ST_SHIFT_DR;
            ST_EXIT1_DR: w_state_next = bus.TMS ? ST_UPD_DR   : ST_PAUSE_DR;
            ST_PAUSE_DR: w_state_next = bus.TMS ? ST_EXIT2_DR : ST_PAUSE_DR;
            ST_EXIT2_DR: w_state_next = bus.TMS ? ST_UPD_DR   : ST_SHIFT_DR;
            ST_UPD_DR:   w_state_next = bus.TMS ? ST_SEL_DR   : ST_RTI;
            ST_SEL_IR:   w_state_next = bus.TMS ? ST_TLR      : ST_CAP_IR;
            ST_CAP_IR:   w_state_next = bus.TMS ? ST_EXIT1_IR : ST_SHIFT_IR;
            ST_SHIFT_IR: w_state_next = bus.TMS ? ST_EXIT1_IR : ST_SHIFT_IR;
            ST_EXIT1_IR: w_state_next = bus.TMS ? ST_UPD_IR   : ST_PAUSE_IR;
            ST_PAUSE_IR: w_state_next = bus.TMS ? ST_EXIT2_IR : ST_PAUSE_IR;
            ST_EXIT2_IR: w_state_next = bus.TMS ? ST_UPD_IR   : ST_SHIFT_IR;
            ST_UPD_IR:   w_state_next = bus.TMS ? ST_SEL_DR   : ST_RTI;
            default:     w_state_next = ST_TLR;
        endcase
    end

    // ---------------- IR / DR datapath ----------------
    // Capture/shift/update act on the edge that leaves the named state.
    always_ff @(posedge TCK) begin
        if (TRST) begin
            r_ir     <= c_ir_reset;
            r_ir_sr  <= 8'h00;
            r_bypass <= 1'b0;
            r_sel_en <= 1'b0;
`ifdef CORE_JTAG_DEBUG_IDCODE_EN
            r_idcode_sr <= IDCODE;
`endif
        end else begin
            case (r_state)
                ST_CAP_IR:   r_ir_sr <= 8'h01;
                ST_SHIFT_IR: r_ir_sr <= {bus.TDI, r_ir_sr[7:1]};
                ST_UPD_IR: begin
                    r_ir     <= r_ir_sr;
                    r_sel_en <= 1'b1;
                end
                ST_CAP_DR: begin
                    r_bypass <= 1'b0;
`ifdef CORE_JTAG_DEBUG_IDCODE_EN
                    r_idcode_sr <= IDCODE;
`endif
                end
                ST_SHIFT_DR: begin
                    r_bypass <= bus.TDI;
`ifdef CORE_JTAG_DEBUG_IDCODE_EN
                    r_idcode_sr <= {bus.TDI, r_idcode_sr[31:1]};
`endif
                end
                default: ;
            endcase
            // Walking into Test-Logic-Reset via TMS clears IR and selection;
            // no state that updates IR can lead there, so ordering is safe.
            if (w_state_next == ST_TLR) begin
                r_ir     <= c_ir_reset;
                r_sel_en <= 1'b0;
            end
        end
    end

    // ---------------- target selection ----------------
    // Descending scan so the lowest matching index wins.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_idx   = 4'd0;
        for (int n = 15; n >= 0; n--) begin
            if (n < NUM_DEBUG_TGTS && r_ir == c_ir_code[n]) begin
                w_sel_valid = r_sel_en;
                w_sel_idx   = 4'(n);
            end
        end
`ifdef CORE_JTAG_DEBUG_IDCODE_EN
        if (w_idcode_sel) w_sel_valid = 1'b0;
`endif
    end

    // ---------------- host TDO ----------------
    always_comb begin
        w_tdo = 1'b0;
        case (r_state)
            ST_SHIFT_IR: w_tdo = r_ir_sr[0];
            ST_SHIFT_DR: begin
                if (w_sel_valid) w_tdo = bus.TGT_TDO[w_sel_idx];
                else             w_tdo = r_bypass;
`ifdef CORE_JTAG_DEBUG_IDCODE_EN
                if (w_idcode_sel) w_tdo = r_idcode_sr[0];
`endif
            end
            default: w_tdo = 1'b0;
        endcase
    end

    // ---------------- per-target fan-out ----------------
    assign w_rst_active = TRST | (r_state == ST_TLR);

    for (genvar n = 0; n < 16; n++) begin : g_tgt
        localparam bit c_present = (n < NUM_DEBUG_TGTS);
        logic w_this_sel;
        assign w_this_sel     = c_present && w_sel_valid && (w_sel_idx == 4'(n));
        assign w_tgt_tck[n]   = c_present ? TCK : 1'b0;
        assign w_tgt_tms[n]   = w_this_sel ? bus.TMS : 1'b0;
        assign w_tgt_tdi[n]   = w_this_sel ? bus.TDI : 1'b1;
        assign w_tgt_trstb[n] = (c_present && w_rst_active) ? c_active_high[n]
                                                            : ~c_active_high[n];
    end

    assign bus.TDO       = w_tdo;
    assign bus.TGT_TCK   = w_tgt_tck;
    assign bus.TGT_TMS   = w_tgt_tms;
    assign bus.TGT_TDI   = w_tgt_tdi;
    assign bus.TGT_TRSTB = w_tgt_trstb;

endmodule
`default_nettype wire

// File: tb/tb_core_jtag_debug.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_jtag_debug
// Description : Directed self-checking bench for core_jtag_debug. Target 0
//               is modelled as a 1-bit bypass-style TAP; target 15 TDO is
//               driven from a fixed pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_jtag_debug;

    logic tck;
    logic trst;
    logic r_model;
    logic tgt15_drv;
    int   total;
    int   bad;

    core_jtag_debug_if u_if ();

    core_jtag_debug u_dut (
        .TCK  (tck),
        .TRST (trst),
        .bus  (u_if.slave)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    // Target 0 model: single-bit DR clocked by its own TCK.
    always @(posedge u_if.TGT_TCK[0]) r_model <= u_if.TGT_TDI[0];
    assign u_if.TGT_TDO = {tgt15_drv, 14'h0000, r_model};

    // Drive the inputs for the next rising edge, then let outputs settle.
    task automatic step(input logic tms, input logic tdi);
        @(negedge tck);
        u_if.TMS = tms;
        u_if.TDI = tdi;
        #1;
    endtask

    // From Run-Test/Idle, scan 8 bits into IR and return to Run-Test/Idle.
    task automatic ir_scan(input logic [7:0] d, output logic [7:0] q);
        q = 8'h00;
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step(k == 7, d[k]);
            q[k] = u_if.TDO;
        end
        step(1'b1, 1'b0); step(1'b0, 1'b0);
    endtask

    // From Run-Test/Idle, scan n bits through DR and return to Run-Test/Idle.
    task automatic dr_scan(input int n, input logic [31:0] d, output logic [31:0] q);
        q = 32'h0;
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        for (int k = 0; k < n; k++) begin
            step(k == n - 1, d[k]);
            q[k] = u_if.TDO;
        end
        step(1'b1, 1'b0); step(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge tck);
        @(negedge tck); #1;
        total++;
        if (u_if.TGT_TRSTB !== 16'h0000) begin
            bad++; $display("FAIL reset_trstb: got %h want %h", u_if.TGT_TRSTB, 16'h0000);
        end
        total++;
        if (u_if.TDO !== 1'b0) begin
            bad++; $display("FAIL reset_tdo: got %b want 0", u_if.TDO);
        end
        trst = 1'b0; u_if.TMS = 1'b0; u_if.TDI = 1'b0;
        step(1'b0, 1'b0);
        total++;
        if (u_if.TGT_TRSTB !== 16'hFFFF) begin
            bad++; $display("FAIL idle_trstb: got %h want %h", u_if.TGT_TRSTB, 16'hFFFF);
        end
        total++;
        if (u_if.TGT_TDI !== 16'hFFFF) begin
            bad++; $display("FAIL idle_tdi: got %h want %h", u_if.TGT_TDI, 16'hFFFF);
        end
        total++;
        if (u_if.TDO !== 1'b0) begin
            bad++; $display("FAIL idle_tdo: got %b want 0", u_if.TDO);
        end
    endtask

    task automatic test_capture_ir();
        logic [7:0] q;
        ir_scan(8'h00, q);
        total++;
        if (q !== 8'h01) begin
            bad++; $display("FAIL capture_ir: got %h want %h", q, 8'h01);
        end
    endtask

    task automatic test_target0();
        logic [7:0]  q;
        logic [31:0] d;
        d = 32'hA5A5_5A5A;
        ir_scan(8'h55, q);
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        for (int k = 0; k < 32; k++) begin
            logic exp_tdo;
            logic last;
            exp_tdo = (k == 0) ? 1'b0 : d[k-1];
            last    = (k == 31);
            step(last, d[k]);
            total++;
            if (u_if.TDO !== exp_tdo) begin
                bad++; $display("FAIL tgt0_tdo[%0d]: got %b want %b", k, u_if.TDO, exp_tdo);
            end
            total++;
            if (u_if.TGT_TMS[0] !== last) begin
                bad++; $display("FAIL tgt0_tms[%0d]: got %b want %b", k, u_if.TGT_TMS[0], last);
            end
            total++;
            if (u_if.TGT_TMS[15:1] !== 15'h0) begin
                bad++; $display("FAIL tgt0_others_tms[%0d]: got %h want 0", k, u_if.TGT_TMS[15:1]);
            end
        end
        step(1'b1, 1'b0); step(1'b0, 1'b0);
    endtask

    task automatic test_target15();
        logic [7:0] q;
        logic [7:0] pat;
        logic [7:0] d;
        pat = 8'hC6;
        d   = 8'h3A;
        ir_scan(8'h64, q);
        step(1'b1, 1'b0);
        total++;
        if (u_if.TGT_TMS !== 16'h8000) begin
            bad++; $display("FAIL tgt15_switch_tms: got %h want %h", u_if.TGT_TMS, 16'h8000);
        end
        step(1'b0, 1'b0); step(1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            tgt15_drv = pat[k];
            step(k == 7, d[k]);
            total++;
            if (u_if.TDO !== pat[k]) begin
                bad++; $display("FAIL tgt15_tdo[%0d]: got %b want %b", k, u_if.TDO, pat[k]);
            end
            total++;
            if (u_if.TGT_TDI !== {d[k], 15'h7FFF}) begin
                bad++; $display("FAIL tgt15_tdi[%0d]: got %h want %h", k, u_if.TGT_TDI, {d[k], 15'h7FFF});
            end
        end
        tgt15_drv = 1'b0;
        step(1'b1, 1'b0); step(1'b0, 1'b0);
    endtask

    task automatic test_bypass_tms_reset();
        logic [7:0]  qi;
        logic [31:0] q;
        ir_scan(8'h00, qi);
        dr_scan(4, 32'h0000_000D, q);
        total++;
        if (q[3:0] !== 4'b1010) begin
            bad++; $display("FAIL bypass_tdo: got %b want %b", q[3:0], 4'b1010);
        end
        ir_scan(8'h55, qi);
        step(1'b0, 1'b0);
        total++;
        if (u_if.TGT_TDI !== 16'hFFFE) begin
            bad++; $display("FAIL reselect_tdi: got %h want %h", u_if.TGT_TDI, 16'hFFFE);
        end
        repeat (5) step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        total++;
        if (u_if.TGT_TMS !== 16'h0000) begin
            bad++; $display("FAIL tlr_tms: got %h want %h", u_if.TGT_TMS, 16'h0000);
        end
        total++;
        if (u_if.TGT_TRSTB !== 16'h0000) begin
            bad++; $display("FAIL tlr_trstb: got %h want %h", u_if.TGT_TRSTB, 16'h0000);
        end
        total++;
        if (u_if.TDO !== 1'b0) begin
            bad++; $display("FAIL tlr_tdo: got %b want 0", u_if.TDO);
        end
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        total++;
        if (u_if.TGT_TDI !== 16'hFFFF) begin
            bad++; $display("FAIL tlr_sel_cleared: got %h want %h", u_if.TGT_TDI, 16'hFFFF);
        end
        total++;
        if (u_if.TGT_TRSTB !== 16'hFFFF) begin
            bad++; $display("FAIL tlr_exit_trstb: got %h want %h", u_if.TGT_TRSTB, 16'hFFFF);
        end
    endtask

`ifdef CORE_JTAG_DEBUG_IDCODE_EN
    task automatic test_idcode();
        logic [31:0] q;
        @(negedge tck);
        trst = 1'b1;
        repeat (2) @(posedge tck);
        @(negedge tck);
        trst = 1'b0; u_if.TMS = 1'b0; u_if.TDI = 1'b0;
        dr_scan(32, 32'h0, q);
        total++;
        if (q !== 32'h1000_0CFD) begin
            bad++; $display("FAIL idcode: got %h want %h", q, 32'h1000_0CFD);
        end
    endtask
`endif

    initial begin
        total = 0;
        bad = 0;
        trst = 1'b1;
        tgt15_drv = 1'b0;
        u_if.TMS = 1'b0;
        u_if.TDI = 1'b0;
        test_reset();
        test_capture_ir();
        test_target0();
        test_target15();
        test_bypass_tms_reset();
`ifdef CORE_JTAG_DEBUG_IDCODE_EN
        test_idcode();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
